// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg
//   Shared definitions for the UART transmit feeder slice: the data width of
//   one UART character, the 2-bit FSM state encoding and a small helper used
//   to size the shared cycle counter.
package uart_tx_feeder_pkg;

  localparam int UART_DATA_W = 8;

  // Feeder FSM encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Larger of two integers, for elaboration-time sizing
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if
//   Bundles the producer write handshake and the transmitter request/active
//   pair of the UART transmit feeder.
//   master : producer + transmitter side (drives wr_data, wr_valid, tx_active)
//   slave  : the feeder (drives wr_ready, tx_data, tx_start)
interface uart_tx_feeder_if;
  import uart_tx_feeder_pkg::*;

  logic [UART_DATA_W-1:0] wr_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_start;
  logic                   tx_active;

  modport master (
    output wr_data, wr_valid, tx_active,
    input  wr_ready, tx_data, tx_start
  );

  modport slave (
    input  wr_data, wr_valid, tx_active,
    output wr_ready, tx_data, tx_start
  );

endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered level/empty/full and a synchronous flush.
//   Ports: clk, reset (async, active-low); push/push_data (ignored when full);
//   pop/head (head is the oldest entry, pop ignored when empty); flush (empties
//   the FIFO next cycle, wins over a push); level/empty/full status.
//   DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   LVL_ZERO = {(PW+1){1'b0}};
  localparam logic [PW:0]   LVL_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   LVL_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]      level_q, level_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             push_ok_s, pop_ok_s;

  // Full blocks a push even when a pop frees a slot in the same cycle
  assign push_ok_s = push && !full_q;
  assign pop_ok_s  = pop && !empty_q;

  // Next-state pointers, level and status flags
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = PTR_ZERO;
      rptr_d  = PTR_ZERO;
      level_d = LVL_ZERO;
    end else begin
      if (push_ok_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_ok_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
    empty_d = (level_d == LVL_ZERO);
    full_d  = (level_d == LVL_FULL);
  end

  // Storage array; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem[wptr_q] <= push_data;
    end
  end

  // Pointer and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= PTR_ZERO;
      rptr_q  <= PTR_ZERO;
      level_q <= LVL_ZERO;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign head  = mem[rptr_q];
  assign level = level_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte buffer and frame sequencer in front of a UART transmitter. Bytes from
//   a producer are queued in a sync_fifo; one byte at a time is presented on
//   tx_data with a tx_start request, frames are paced by tx_active, and a
//   low tx_start gap follows every frame or aborted request.
//   Ports: clk, reset (async, active-low); enable (allows launching frames);
//   flush (empties the queue); bus (uart_tx_feeder_if.slave: write handshake
//   and transmitter request); level/empty/full queue status; err_timeout and
//   err_overflow sticky error flags.
//   Build option UART_TX_FEEDER_STATS_EN adds sent_count and drop_count.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int CLOCKS_PER_BIT = 10,
  parameter int GAP_CLOCKS     = 2 * CLOCKS_PER_BIT,
  parameter int REQ_TIMEOUT    = 4 * CLOCKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  uart_tx_feeder_if.slave        bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full,
  output logic                   err_timeout,
  output logic                   err_overflow
`ifdef UART_TX_FEEDER_STATS_EN
  ,
  output logic [15:0]            sent_count,
  output logic [15:0]            drop_count
`endif
);
  localparam int CNT_W = $clog2(max_int(GAP_CLOCKS, REQ_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CLOCKS - 1);

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc_s;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d, fifo_head_s;
  logic                   tx_start_q, tx_start_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   err_overflow_q, err_overflow_d;
  logic                   pop_s, drop_s, timeout_s;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.wr_valid),
    .push_data (bus.wr_data),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .flush     (flush),
    .level     (level),
    .empty     (empty),
    .full      (full)
  );

  assign bus.wr_ready = ~full;

  // Shared REQ/GAP timer saturates instead of wrapping
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign drop_s    = bus.wr_valid && full;
  assign timeout_s = (state_q == ST_REQ) && !bus.tx_active && (cnt_q == REQ_LAST);

  assign err_timeout_d  = err_timeout_q | timeout_s;
  assign err_overflow_d = err_overflow_q | drop_s;

  // Frame sequencer: IDLE -> REQ -> BUSY -> GAP, or REQ -> GAP on timeout
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !empty) begin
          pop_s      = 1'b1;
          tx_data_d  = fifo_head_s;
          tx_start_d = 1'b1;
          cnt_d      = CNT_ZERO;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.tx_active) begin
          tx_start_d = 1'b0;
          state_d    = ST_BUSY;
        end else if (cnt_q == REQ_LAST) begin
          // Abort: the byte stays in tx_data but is never sent
          tx_start_d = 1'b0;
          cnt_d      = CNT_ZERO;
          state_d    = ST_GAP;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_BUSY: begin
        if (!bus.tx_active) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_GAP;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_start_d = 1'b0;
        cnt_d      = CNT_ZERO;
      end
    endcase
  end

  // Sequencer, output and sticky error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= CNT_ZERO;
      tx_data_q      <= 8'h00;
      tx_start_q     <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      err_timeout_q  <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign err_timeout  = err_timeout_q;
  assign err_overflow = err_overflow_q;

`ifdef UART_TX_FEEDER_STATS_EN
  logic [15:0] sent_q, sent_d, drop_q, drop_d;
  logic        sent_s;

  // A frame counts as sent when the transmitter releases tx_active
  assign sent_s = (state_q == ST_BUSY) && !bus.tx_active;
  assign sent_d = sent_q + {15'd0, sent_s};
  // A dropped write and a timeout can land in the same cycle
  assign drop_d = drop_q + {15'd0, drop_s} + {15'd0, timeout_s};

  // Wrapping statistics counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_q <= 16'd0;
      drop_q <= 16'd0;
    end else begin
      sent_q <= sent_d;
      drop_q <= drop_d;
    end
  end

  assign sent_count = sent_q;
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
//   Scoreboard bench: every accepted write pushes its byte into exp_q; a
//   monitor pops and compares whenever tx_start rises. A small transmitter
//   model answers requests with tx_active. Status outputs are compared against
//   the queue model on every driven cycle.
module tb_uart_tx_feeder;
  import uart_tx_feeder_pkg::*;

  localparam int DEPTH = 16;
  localparam int CPB   = 10;
  localparam int GAP   = 2 * CPB;
  localparam int TMO   = 4 * CPB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic empty, full, err_timeout, err_overflow;
`ifdef UART_TX_FEEDER_STATS_EN
  logic [15:0] sent_count, drop_count;
`endif

  uart_tx_feeder_if bus();

  uart_tx_feeder #(
    .DEPTH(DEPTH), .CLOCKS_PER_BIT(CPB), .GAP_CLOCKS(GAP), .REQ_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .bus(bus),
    .level(level), .empty(empty), .full(full),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
`ifdef UART_TX_FEEDER_STATS_EN
    , .sent_count(sent_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  bit exp_ovf = 1'b0;
  bit exp_tmo = 1'b0;
  int exp_sent = 0;
  int exp_drop = 0;
  bit in_reset = 1'b1;
  int tx_mode = 0;      // 0: transmitter answers requests, 1: it ignores them
  bit rand_tx = 1'b0;
  int resp_dly = 3;
  int frame_len = 12;
  int rise_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_status();
    check("level", 32'(level), 32'(exp_q.size()));
    check("empty", 32'(empty), 32'(exp_q.size() == 0));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("wr_ready", 32'(bus.wr_ready), 32'(exp_q.size() != DEPTH));
    check("err_overflow", 32'(err_overflow), 32'(exp_ovf));
    check("err_timeout", 32'(err_timeout), 32'(exp_tmo));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'h00);
    check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    check({tag, "_err_overflow"}, 32'(err_overflow), 32'd0);
`ifdef UART_TX_FEEDER_STATS_EN
    check({tag, "_sent_count"}, 32'(sent_count), 32'd0);
    check({tag, "_drop_count"}, 32'(drop_count), 32'd0);
`endif
  endtask

  // Called at a negedge; drives one write for one cycle and updates the model
  task automatic do_write(input logic [7:0] b);
    check_status();
    bus.wr_data = b;
    bus.wr_valid = 1'b1;
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(b);
    end else begin
      exp_ovf = 1'b1;
      exp_drop++;
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < GAP + 4 && n < 20000) begin
      @(negedge clk);
      n++;
      check_status();
      if (exp_q.size() == 0 && !bus.tx_start && !bus.tx_active) quiet++;
      else quiet = 0;
    end
    check({tag, "_drained"}, 32'(quiet >= GAP + 4), 32'd1);
  endtask

  task automatic wait_active(input string tag);
    int n = 0;
    while (!bus.tx_active && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tx_active_seen"}, 32'(bus.tx_active), 32'd1);
  endtask

  // Transmitter model: answers a pending request after a delay, then runs a frame
  initial begin : xmit
    int d, l;
    bus.tx_active = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1 && tx_mode == 0) begin
        d = rand_tx ? int'($urandom_range(1, 6)) : resp_dly;
        l = rand_tx ? int'($urandom_range(2, 15)) : frame_len;
        repeat (d - 1) @(negedge clk);
        bus.tx_active = 1'b1;
        repeat (l) @(negedge clk);
        bus.tx_active = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each request and checks frame timing
  initial begin : mon
    logic [7:0] e;
    logic prev_start, prev_active;
    logic [7:0] held;
    int rise_cyc, end_cyc;
    prev_start = 1'b0; prev_active = 1'b0; held = 8'h00;
    rise_cyc = 0; end_cyc = -1000;
    forever begin
      @(posedge clk);
      #1;
      if (in_reset) begin
        held = bus.tx_data;
        end_cyc = -1000;
      end else begin
        if (bus.tx_start && !prev_start) begin
          rise_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_tx_start_data", 32'(bus.tx_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(bus.tx_data), 32'(e));
          end
          check("gap_before_start", 32'(cyc - end_cyc > GAP), 32'd1);
          held = bus.tx_data;
          rise_cyc = cyc;
        end
        if (!bus.tx_start && prev_start) begin
          check("tx_data_hold_req", 32'(bus.tx_data), 32'(held));
          if (!bus.tx_active) begin
            check("timeout_len", 32'(cyc - rise_cyc), 32'(TMO));
            check("timeout_flag", 32'(err_timeout), 32'd1);
            exp_tmo = 1'b1;
            exp_drop++;
            end_cyc = cyc;
          end else begin
            check("start_drop_on_active_rise", 32'(prev_active), 32'd0);
          end
        end
        if (bus.tx_active && prev_active) begin
          check("start_low_in_frame", 32'(bus.tx_start), 32'd0);
        end
        if (!bus.tx_active && prev_active) begin
          check("tx_data_hold_frame", 32'(bus.tx_data), 32'(held));
          end_cyc = cyc;
          exp_sent++;
        end
      end
      prev_start = bus.tx_start;
      prev_active = bus.tx_active;
    end
  end

  initial begin : main
    int rc;
    int n;
    bus.wr_data = 8'h00;
    bus.wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);
    in_reset = 1'b0;
    check_status();
    enable = 1'b1;

    // Single byte, transmitter answers after 3 clocks
    resp_dly = 3; frame_len = 12;
    do_write(8'hA5);
    wait_idle("t1");

    // Fill to full with launching blocked, then overflow once
    enable = 1'b0;
    for (int i = 0; i < 17; i++) do_write(8'(i));
    check_status();
    check("t2_full", 32'(full), 32'd1);
    check("t2_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("t2_level", 32'(level), 32'd16);
    check("t2_err_overflow", 32'(err_overflow), 32'd1);
    enable = 1'b1;
    wait_idle("t2");

    // Request timeout, then the next byte is served after the gap
    tx_mode = 1;
    do_write(8'h3C);
    do_write(8'hC3);
    n = 0;
    while (!err_timeout && n < 200) begin
      @(negedge clk);
      n++;
      check_status();
    end
    tx_mode = 0;
    check("t3_err_timeout", 32'(err_timeout), 32'd1);
    wait_idle("t3");

    // Writes while disabled produce no requests until enable rises
    enable = 1'b0;
    rc = rise_count;
    for (int i = 0; i < 3; i++) do_write(8'($urandom));
    repeat (60) begin
      @(negedge clk);
      check_status();
    end
    check("t4_no_start", 32'(rise_count), 32'(rc));
    check("t4_level", 32'(level), 32'd3);
    enable = 1'b1;
    wait_idle("t4");
    check("t4_frames", 32'(rise_count), 32'(rc + 3));

    // Flush while a frame is in flight with five bytes queued
    frame_len = 30;
    for (int i = 0; i < 6; i++) do_write(8'($urandom));
    wait_active("t5");
    repeat (2) @(negedge clk);
    check("t5_queued", 32'(level), 32'd5);
    rc = rise_count;
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    check("t5_level", 32'(level), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_frame_running", 32'(bus.tx_active), 32'd1);
    wait_idle("t5");
    check("t5_no_more_start", 32'(rise_count), 32'(rc));

    // Randomized traffic with enable toggling and random transmitter timing
    rand_tx = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 1) == 1) begin
        do_write(8'($urandom));
      end else begin
        @(negedge clk);
        check_status();
      end
    end
    enable = 1'b1;
    wait_idle("rand");
`ifdef UART_TX_FEEDER_STATS_EN
    check("sent_count", 32'(sent_count), 32'(exp_sent[15:0]));
    check("drop_count", 32'(drop_count), 32'(exp_drop[15:0]));
`endif

    // Reset asserted while a frame is in flight
    rand_tx = 1'b0;
    frame_len = 20;
    do_write(8'h5A);
    wait_active("t6");
    repeat (2) @(negedge clk);
    in_reset = 1'b1;
    reset = 1'b0;
    #1;
    check_reset_vals("t6");
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_tmo = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (bus.tx_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_status();
    end
    check("t6_no_start", 32'(bus.tx_start), 32'd0);

    $display("frames observed %0d, drops observed %0d", exp_sent, exp_drop);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
